// File: rtl/toggle_event_receiver.sv
// Receive side of a toggle-encoded event link: synchronises the remote level,
// turns each level change into one queued event, and hands events out via valid/ready.
module toggle_event_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             evt_valid,
    output logic             evt_pulse,
    output logic [CNT_W-1:0] pending,
    output logic [TOT_W-1:0] total,
    output logic             overflow,
    output logic             tog_sync
);

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   tog_edge;
    logic                   accept;
    logic                   drop;
    logic [CNT_W-1:0]       pending_next;

    assign tog_sync = sync[SYNC_STAGES-1];
    assign tog_edge = tog_sync ^ prev;
    assign accept   = evt_valid & evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tog_in};
            prev <= tog_sync;
        end
    end

    // A simultaneous arrival and departure leaves the queue depth unchanged.
    always_comb begin
        pending_next = pending;
        drop         = 1'b0;
        case ({tog_edge, accept})
            2'b10: begin
                if (pending == PEND_MAX) begin
                    drop = 1'b1;
                end else begin
                    pending_next = pending + CNT_W'(1);
                end
            end
            2'b01:   pending_next = pending - CNT_W'(1);
            default: pending_next = pending;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            evt_valid <= 1'b0;
            evt_pulse <= 1'b0;
            total     <= '0;
            overflow  <= 1'b0;
        end else begin
            pending   <= pending_next;
            evt_valid <= (pending_next != '0);
            evt_pulse <= tog_edge;
            if (tog_edge) begin
                total <= total + TOT_W'(1);
            end
            // A fresh drop takes priority over a clear request in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver at default parameters: latency,
// handshake, saturation/overflow and asynchronous reset behaviour.
module tb_toggle_event_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tog_in;
    logic        evt_ready;
    logic        ovf_clr;
    logic        evt_valid;
    logic        evt_pulse;
    logic [3:0]  pending;
    logic [15:0] total;
    logic        overflow;
    logic        tog_sync;

    int checks = 0;
    int errors = 0;

    toggle_event_receiver #(
        .SYNC_STAGES(2),
        .CNT_W(4),
        .TOT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tog_in(tog_in),
        .evt_ready(evt_ready),
        .ovf_clr(ovf_clr),
        .evt_valid(evt_valid),
        .evt_pulse(evt_pulse),
        .pending(pending),
        .total(total),
        .overflow(overflow),
        .tog_sync(tog_sync)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Each toggle is held long enough for its event to be fully registered.
    task automatic applyStimulus(input int toggles);
        for (int i = 0; i < toggles; i++) begin
            tog_in = ~tog_in;
            tick(4);
        end
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        tog_in    = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Single event latency
        doReset();
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst_total", 32'(total), 32'd0);
        checkOutput("rst_tog_sync", 32'(tog_sync), 32'd0);
        tog_in = 1'b1;
        tick(1);
        checkOutput("lat_sync_e0", 32'(tog_sync), 32'd0);
        tick(1);
        checkOutput("lat_sync_e1", 32'(tog_sync), 32'd1);
        checkOutput("lat_pulse_e1", 32'(evt_pulse), 32'd0);
        checkOutput("lat_pend_e1", 32'(pending), 32'd0);
        tick(1);
        checkOutput("lat_pulse_e2", 32'(evt_pulse), 32'd1);
        checkOutput("lat_pend_e2", 32'(pending), 32'd1);
        checkOutput("lat_valid_e2", 32'(evt_valid), 32'd1);
        checkOutput("lat_total_e2", 32'(total), 32'd1);
        tick(1);
        checkOutput("lat_pulse_e3", 32'(evt_pulse), 32'd0);

        // Queue five then drain
        doReset();
        applyStimulus(5);
        checkOutput("q5_pending", 32'(pending), 32'd5);
        checkOutput("q5_total", 32'(total), 32'd5);
        evt_ready = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            tick(1);
            checkOutput("drain_pending", 32'(pending), 32'(k));
        end
        checkOutput("drain_valid", 32'(evt_valid), 32'd0);
        tick(1);
        checkOutput("empty_no_underflow", 32'(pending), 32'd0);

        // Consumer always ready
        for (int k = 0; k < 3; k++) begin
            tog_in = ~tog_in;
            tick(3);
            checkOutput("rdy_pend_up", 32'(pending), 32'd1);
            tick(1);
            checkOutput("rdy_pend_down", 32'(pending), 32'd0);
        end
        checkOutput("rdy_overflow", 32'(overflow), 32'd0);
        checkOutput("rdy_total", 32'(total), 32'd8);
        evt_ready = 1'b0;

        // Edge and accept in the same cycle
        doReset();
        applyStimulus(3);
        tog_in = ~tog_in;
        tick(2);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checkOutput("both_pending", 32'(pending), 32'd3);
        checkOutput("both_total", 32'(total), 32'd4);
        tick(1);
        checkOutput("both_pending_hold", 32'(pending), 32'd3);

        // Saturation and overflow
        doReset();
        applyStimulus(15);
        checkOutput("sat15_pending", 32'(pending), 32'd15);
        checkOutput("sat15_overflow", 32'(overflow), 32'd0);
        applyStimulus(1);
        checkOutput("sat16_pending", 32'(pending), 32'd15);
        checkOutput("sat16_overflow", 32'(overflow), 32'd1);
        checkOutput("sat16_total", 32'(total), 32'd16);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checkOutput("clr_overflow", 32'(overflow), 32'd0);
        checkOutput("clr_pending", 32'(pending), 32'd15);
        tog_in = ~tog_in;
        tick(2);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checkOutput("full_accept_pending", 32'(pending), 32'd15);
        checkOutput("full_accept_overflow", 32'(overflow), 32'd0);
        checkOutput("full_accept_total", 32'(total), 32'd17);
        tick(1);
        tog_in = ~tog_in;
        tick(2);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checkOutput("set_wins_overflow", 32'(overflow), 32'd1);
        checkOutput("set_wins_total", 32'(total), 32'd18);

        // Asynchronous reset mid-operation
        doReset();
        applyStimulus(7);
        checkOutput("pre_rst_pending", 32'(pending), 32'd7);
        tog_in = ~tog_in;
        tick(1);
        rst_n = 1'b0;
        #2;
        checkOutput("async_pending", 32'(pending), 32'd0);
        checkOutput("async_valid", 32'(evt_valid), 32'd0);
        checkOutput("async_total", 32'(total), 32'd0);
        checkOutput("async_pulse", 32'(evt_pulse), 32'd0);
        checkOutput("async_overflow", 32'(overflow), 32'd0);
        checkOutput("async_tog_sync", 32'(tog_sync), 32'd0);
        tog_in = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        checkOutput("post_rst_pending", 32'(pending), 32'd1);
        checkOutput("post_rst_total", 32'(total), 32'd1);
        checkOutput("post_rst_valid", 32'(evt_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
